// File: rtl/uart_pkg.sv
// Shared UART constants so uart_tx, uart_rx and the TX arbiter agree on defaults.
package uart_pkg;

    localparam int DATA_BITS_DEFAULT = 8;

endpackage

// File: rtl/uart_tx_arbiter_rr_select.sv
// Rotating-priority encoder: picks the first asserted request after i_base (with wrap),
// or only i_lockedId while a lock is held. Purely combinational, reusable for any shared resource.
module rr_select #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDW-1:0]     i_base,
    input  logic               i_lock,
    input  logic [IDW-1:0]     i_lockedId,
    output logic [IDW-1:0]     o_sel,
    output logic               o_selValid
);

    int w_idx;

    // Scan from the farthest candidate back to the nearest so the nearest valid one wins.
    always_comb begin
        o_sel      = '0;
        o_selValid = 1'b0;
        w_idx      = 0;
        if (i_lock) begin
            o_sel      = i_lockedId;
            o_selValid = i_req[i_lockedId];
        end else begin
            for (int k = NUM_REQ; k >= 1; k--) begin
                w_idx = int'(i_base) + k;
                if (w_idx >= NUM_REQ) begin
                    w_idx = w_idx - NUM_REQ;
                end
                if (i_req[IDW'(w_idx)]) begin
                    o_sel      = IDW'(w_idx);
                    o_selValid = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx between NUM_REQ byte sources with round-robin arbitration
// and an optional packet lock so multi-byte messages are never interleaved.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter  int NUM_REQ   = 4,
    parameter  int DATA_BITS = DATA_BITS_DEFAULT,
    parameter  int LOCK_EN   = 1,
    localparam int IDW       = $clog2(NUM_REQ)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ-1:0]           req_last,
    input  logic [NUM_REQ*DATA_BITS-1:0] req_data,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         tx_start,
    output logic [DATA_BITS-1:0]         tx_data,
    input  logic                         tx_ready,
    output logic                         busy,
    output logic [IDW-1:0]               grant_id,
    output logic                         locked
);

    typedef enum logic [1:0] {
        IDLE,
        START,
        HOLD,
        WAIT
    } arb_state_t;

    arb_state_t           r_state;
    arb_state_t           w_nextState;
    logic                 r_txStart;
    logic [DATA_BITS-1:0] r_txData;
    logic [IDW-1:0]       r_grantId;
    logic                 r_locked;
    logic [IDW-1:0]       w_sel;
    logic                 w_selValid;
    logic                 w_lock;
    logic                 w_transfer;

    assign w_lock = (LOCK_EN != 0) && r_locked;

    rr_select #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_rrSelect (
        .i_req      (req_valid),
        .i_base     (r_grantId),
        .i_lock     (w_lock),
        .i_lockedId (r_grantId),
        .o_sel      (w_sel),
        .o_selValid (w_selValid)
    );

    assign w_transfer = (r_state == IDLE) && tx_ready && w_selValid;

    always_comb begin
        req_ready        = '0;
        req_ready[w_sel] = w_transfer;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // HOLD exists because uart_tx only drops ready the cycle after it sees start.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_transfer) w_nextState = START;
            START:   w_nextState = HOLD;
            HOLD:    w_nextState = WAIT;
            WAIT:    if (tx_ready) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_txStart <= 1'b0;
            r_txData  <= '0;
            r_grantId <= IDW'(NUM_REQ - 1);
            r_locked  <= 1'b0;
        end else begin
            r_txStart <= w_transfer;
            if (w_transfer) begin
                r_txData  <= req_data[w_sel*DATA_BITS +: DATA_BITS];
                r_grantId <= w_sel;
                r_locked  <= (LOCK_EN != 0) && !req_last[w_sel];
            end
        end
    end

    assign tx_start = r_txStart;
    assign tx_data  = r_txData;
    assign grant_id = r_grantId;
    assign locked   = r_locked;
    assign busy     = (r_state != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a locked (A) and an unlocked (B) instance,
// each driving a small uart_tx ready model.
module tb_uart_tx_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam int IDW  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    logic [NREQ-1:0]    aReqValid, aReqLast, aReqReady;
    logic [NREQ*DW-1:0] aReqData;
    logic               aTxStart, aTxReady, aBusy, aLocked, aHoldOff;
    logic [DW-1:0]      aTxData;
    logic [IDW-1:0]     aGrantId;

    logic [NREQ-1:0]    bReqValid, bReqLast, bReqReady;
    logic [NREQ*DW-1:0] bReqData;
    logic               bTxStart, bTxReady, bBusy, bLocked, bReq0, bRun;
    logic [DW-1:0]      bTxData;
    logic [IDW-1:0]     bGrantId;

    int aFrameLen = 12;
    int aCnt = 0;
    int bCnt = 0;
    int bIdx = 0;
    int aStartViol = 0;
    int aReadyCnt[NREQ] = '{0, 0, 0, 0};
    logic [DW-1:0] aLog[$];
    logic [DW-1:0] bLog[$];

    int checkCount = 0;
    int errorCount = 0;

    uart_tx_arbiter #(.NUM_REQ(NREQ), .DATA_BITS(DW), .LOCK_EN(1)) dutA (
        .clk(clk), .rst(rst), .req_valid(aReqValid), .req_last(aReqLast), .req_data(aReqData),
        .req_ready(aReqReady), .tx_start(aTxStart), .tx_data(aTxData), .tx_ready(aTxReady),
        .busy(aBusy), .grant_id(aGrantId), .locked(aLocked)
    );

    uart_tx_arbiter #(.NUM_REQ(NREQ), .DATA_BITS(DW), .LOCK_EN(0)) dutB (
        .clk(clk), .rst(rst), .req_valid(bReqValid), .req_last(bReqLast), .req_data(bReqData),
        .req_ready(bReqReady), .tx_start(bTxStart), .tx_data(bTxData), .tx_ready(bTxReady),
        .busy(bBusy), .grant_id(bGrantId), .locked(bLocked)
    );

    // uart_tx stand-in: ready drops the cycle after start and returns after a frame; not reset by rst.
    assign aTxReady = (aCnt == 0) && !aHoldOff;
    assign bTxReady = (bCnt == 0);

    always @(posedge clk) begin
        if (aTxStart) aCnt <= aFrameLen;
        else if (aCnt > 0) aCnt <= aCnt - 1;
        if (bTxStart) bCnt <= 12;
        else if (bCnt > 0) bCnt <= bCnt - 1;
    end

    always @(posedge clk) begin
        if (aTxStart) begin
            aLog.push_back(aTxData);
            if (aCnt != 0) aStartViol++;
        end
        if (bTxStart) bLog.push_back(bTxData);
        for (int i = 0; i < NREQ; i++) aReadyCnt[i] += int'(aReqReady[i]);
    end

    // Requester 1 of instance B streams 0x01, 0x02, 0x03; requester 0 is a constant 0xFF source.
    always_comb begin
        bReqValid = {2'b00, bRun && (bIdx < 3), bReq0};
        bReqLast  = '0;
        bReqData  = {16'h0000, 8'(bIdx + 1), 8'hFF};
    end

    always @(posedge clk) begin
        if (bReqValid[1] && bReqReady[1]) bIdx <= bIdx + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int id, input logic valid, input logic last, input logic [DW-1:0] data);
        aReqValid[id]        = valid;
        aReqLast[id]         = last;
        aReqData[id*DW +: DW] = data;
    endtask

    function automatic logic [31:0] aLogAt(input int i);
        if (i < aLog.size()) return 32'(aLog[i]);
        return 32'hDEAD;
    endfunction

    function automatic logic [31:0] bLogAt(input int i);
        if (i < bLog.size()) return 32'(bLog[i]);
        return 32'hDEAD;
    endfunction

    // Waits for requester id to be offered ready, then lets the transfer edge pass.
    task automatic waitAccept(input int id, input int budget, input string tag);
        int n = 0;
        #1;
        while (!aReqReady[id] && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        checkOutput(tag, 32'(aReqReady[id]), 32'd1);
        @(negedge clk);
    endtask

    task automatic waitIdle(input int budget);
        int n = 0;
        #1;
        while ((aBusy || !aTxReady) && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        checkOutput("idle reached", 32'(aBusy), 32'd0);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst       = 1'b1;
        aReqValid = '0;
        aReqLast  = '0;
        aReqData  = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int base;
        int n;
        logic seen;
        aReqValid = '0;
        aReqLast  = '0;
        aReqData  = '0;
        aHoldOff  = 1'b0;
        bReq0     = 1'b0;
        bRun      = 1'b0;

        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset tx_start", 32'(aTxStart), 32'd0);
        checkOutput("reset tx_data", 32'(aTxData), 32'd0);
        checkOutput("reset busy", 32'(aBusy), 32'd0);
        checkOutput("reset locked", 32'(aLocked), 32'd0);
        checkOutput("reset grant_id", 32'(aGrantId), 32'd3);
        checkOutput("reset req_ready", 32'(aReqReady), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Single requester.
        @(negedge clk);
        applyStimulus(2, 1'b1, 1'b1, 8'hA5);
        waitAccept(2, 20, "single accept");
        checkOutput("single tx_start", 32'(aTxStart), 32'd1);
        checkOutput("single tx_data", 32'(aTxData), 32'hA5);
        checkOutput("single grant_id", 32'(aGrantId), 32'd2);
        checkOutput("single busy", 32'(aBusy), 32'd1);
        applyStimulus(2, 1'b0, 1'b0, 8'h00);
        @(negedge clk);
        #1;
        checkOutput("single start pulse width", 32'(aTxStart), 32'd0);
        waitIdle(100);
        checkOutput("single log size", 32'(aLog.size()), 32'd1);
        checkOutput("single log byte", aLogAt(0), 32'hA5);
        checkOutput("single ready cycles", 32'(aReadyCnt[2]), 32'd1);

        // Fairness: all four valid, one byte each per rotation.
        doReset();
        base = aLog.size();
        for (int i = 0; i < NREQ; i++) applyStimulus(i, 1'b1, 1'b1, 8'(8'h10 + i));
        n = 0;
        while (aLog.size() < base + 8 && n < 600) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < NREQ; i++) applyStimulus(i, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 8; i++) checkOutput("fair order", aLogAt(base + i), 32'(8'h10 + (i % 4)));
        waitIdle(100);

        // Packet lock on instance A.
        doReset();
        base = aLog.size();
        applyStimulus(1, 1'b1, 1'b0, 8'h01);
        waitAccept(1, 20, "lock accept 01");
        checkOutput("lock held after 01", 32'(aLocked), 32'd1);
        applyStimulus(0, 1'b1, 1'b1, 8'hFF);
        applyStimulus(1, 1'b1, 1'b0, 8'h02);
        waitAccept(1, 100, "lock accept 02");
        checkOutput("lock held after 02", 32'(aLocked), 32'd1);
        applyStimulus(1, 1'b1, 1'b1, 8'h03);
        waitAccept(1, 100, "lock accept 03");
        checkOutput("lock released after 03", 32'(aLocked), 32'd0);
        applyStimulus(1, 1'b0, 1'b0, 8'h00);
        waitAccept(0, 100, "lock accept FF");
        applyStimulus(0, 1'b0, 1'b0, 8'h00);
        waitIdle(100);
        checkOutput("lock byte 0", aLogAt(base + 0), 32'h01);
        checkOutput("lock byte 1", aLogAt(base + 1), 32'h02);
        checkOutput("lock byte 2", aLogAt(base + 2), 32'h03);
        checkOutput("lock byte 3", aLogAt(base + 3), 32'hFF);

        // Same traffic on the unlocked instance B interleaves.
        @(negedge clk);
        bRun = 1'b1;
        n = 0;
        while (bLog.size() < 1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        bReq0 = 1'b1;
        n = 0;
        while (bLog.size() < 5 && n < 500) begin
            @(negedge clk);
            checkOutput("nolock locked low", 32'(bLocked), 32'd0);
            n++;
        end
        bReq0 = 1'b0;
        bRun  = 1'b0;
        checkOutput("nolock byte 0", bLogAt(0), 32'h01);
        checkOutput("nolock byte 1", bLogAt(1), 32'hFF);
        checkOutput("nolock byte 2", bLogAt(2), 32'h02);
        checkOutput("nolock byte 3", bLogAt(3), 32'hFF);
        checkOutput("nolock byte 4", bLogAt(4), 32'h03);

        // Back-pressure: tx_ready held low for 50 cycles.
        doReset();
        base = aLog.size();
        aHoldOff = 1'b1;
        applyStimulus(0, 1'b1, 1'b1, 8'h77);
        seen = 1'b0;
        repeat (50) begin
            @(negedge clk);
            #1;
            seen = seen | (aReqReady != '0) | aTxStart;
        end
        checkOutput("backpressure no activity", 32'(seen), 32'd0);
        aHoldOff = 1'b0;
        #1;
        checkOutput("backpressure ready on release", 32'(aReqReady), 32'h1);
        waitAccept(0, 2, "backpressure accept");
        applyStimulus(0, 1'b0, 1'b0, 8'h00);
        waitIdle(100);
        checkOutput("backpressure byte", aLogAt(base), 32'h77);

        // Reset in the middle of a long frame.
        doReset();
        base = aLog.size();
        aFrameLen = 300;
        applyStimulus(0, 1'b1, 1'b1, 8'h55);
        waitAccept(0, 20, "midreset accept 55");
        applyStimulus(0, 1'b0, 1'b0, 8'h00);
        repeat (100) @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("midreset tx_start", 32'(aTxStart), 32'd0);
        checkOutput("midreset tx_data", 32'(aTxData), 32'd0);
        checkOutput("midreset busy", 32'(aBusy), 32'd0);
        checkOutput("midreset grant_id", 32'(aGrantId), 32'd3);
        checkOutput("midreset locked", 32'(aLocked), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        applyStimulus(3, 1'b1, 1'b1, 8'hC3);
        waitAccept(3, 400, "midreset accept C3");
        applyStimulus(3, 1'b0, 1'b0, 8'h00);
        aFrameLen = 12;
        waitIdle(400);
        checkOutput("midreset no premature start", 32'(aStartViol), 32'd0);
        checkOutput("midreset log size", 32'(aLog.size() - base), 32'd2);
        checkOutput("midreset byte", aLogAt(base + 1), 32'hC3);

        // Locked requester stalls; others wait until its message ends.
        doReset();
        base = aLog.size();
        applyStimulus(2, 1'b1, 1'b0, 8'h20);
        waitAccept(2, 20, "stall accept 20");
        applyStimulus(2, 1'b0, 1'b0, 8'h00);
        applyStimulus(0, 1'b1, 1'b1, 8'h0F);
        repeat (1000) @(negedge clk);
        #1;
        checkOutput("stall no new start", 32'(aLog.size() - base), 32'd1);
        checkOutput("stall locked", 32'(aLocked), 32'd1);
        checkOutput("stall req_ready", 32'(aReqReady), 32'd0);
        applyStimulus(2, 1'b1, 1'b1, 8'h21);
        waitAccept(2, 50, "stall accept 21");
        applyStimulus(2, 1'b0, 1'b0, 8'h00);
        waitAccept(0, 100, "stall accept 0F");
        applyStimulus(0, 1'b0, 1'b0, 8'h00);
        waitIdle(100);
        checkOutput("stall byte 0", aLogAt(base + 0), 32'h20);
        checkOutput("stall byte 1", aLogAt(base + 1), 32'h21);
        checkOutput("stall byte 2", aLogAt(base + 2), 32'h0F);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one uart_tx instance between NUM_REQ independent byte sources.
- Round-robin arbitration per byte, with an optional packet lock (req_last) so multi-byte messages are never interleaved.
- Sits between requesters (command/response logic, debug, status reporters) and uart_tx; drives its start/data_in and watches its ready.
- Does not instantiate uart_tx; the parent connects tx_* ports to it.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- DATA_BITS, 8, byte width; must match uart_tx DATA_BITS.
- LOCK_EN, 1, 1 = hold grant until req_last byte accepted; 0 = re-arbitrate every byte.
- Localparam IDW = $clog2(NUM_REQ).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- req_valid  in  NUM_REQ  per-requester byte available
- req_last  in  NUM_REQ  per-requester "this byte ends the message"; ignored when LOCK_EN=0
- req_data  in  NUM_REQ*DATA_BITS  packed bytes, requester i at [i*DATA_BITS +: DATA_BITS]
- req_ready  out  NUM_REQ  byte accepted this cycle (transfer = valid & ready)
- tx_start  out  1  one-cycle start pulse to uart_tx
- tx_data  out  DATA_BITS  byte to uart_tx, stable from start pulse until tx_ready returns
- tx_ready  in  1  uart_tx ready (idle)
- busy  out  1  high whenever state != IDLE
- grant_id  out  IDW  index of last/current granted requester
- locked  out  1  packet lock held

Behaviour:
- Reset (async, any state): state=IDLE, tx_start=0, tx_data=0, busy=0, locked=0, grant_id=NUM_REQ-1 (so requester 0 has top priority first), req_ready=0.
- req_ready combinational: req_ready[i] = (state==IDLE) & tx_ready & sel_valid & (sel==i); at most one bit high.
- Selection when unlocked: first i with req_valid[i], searching from grant_id+1 upward with wrap modulo NUM_REQ. When locked: only requester grant_id is eligible; others are ignored even if valid.
- FSM:
  - IDLE: on transfer, register tx_data=req_data[sel], grant_id=sel, tx_start=1 -> START.
    - With LOCK_EN=1, locked <= ~req_last[sel].
    - No eligible valid, or tx_ready=0: stay.
  - START (1 cycle): tx_start=1 visible to uart_tx; next cycle tx_start=0 -> HOLD.
  - HOLD (1 cycle): tx_ready is ignored (uart_tx drops ready the cycle after start) -> WAIT.
  - WAIT: stay while tx_ready=0; on tx_ready=1 -> IDLE.
- Throughput: a new byte may be accepted in the first IDLE cycle after tx_ready returns. Minimum 3 cycles of arbiter overhead between bytes beyond the uart_tx frame time.
- Locked requester deasserting valid: lock persists and the arbiter waits indefinitely. There is no timeout.
- Simultaneous valids: round-robin order, strictly fair; each requester is served at most once per rotation when unlocked.
- tx_ready low at/after reset exit: no transfer until it is high.
- Mid-frame reset: the arbiter returns to IDLE but does not reset uart_tx. The first new transfer waits for tx_ready=1, so no frame is corrupted by a premature start.
- req_data of non-selected requesters and req_last while not transferring: don't-care.

Decomposition:
- Package uart_pkg: DATA_BITS default constant, shared with uart_tx/uart_rx parameter defaults.
- FSM state enum arb_state_t (IDLE, START, HOLD, WAIT) is local to the module.
- Sub-module rr_select: combinational rotate-priority encoder with inputs req, mask-base pointer, lock, locked_id and outputs sel, sel_valid. Reusable for other shared resources.

Test Plan:
- Single requester: NUM_REQ=4, req 2 sends 0xA5 with last=1 -> one tx_start pulse, tx_data=0xA5, grant_id=2, req_ready[2] high for exactly one cycle; the looped-back uart_rx outputs 0xA5.
- Fairness: all four valid continuously, each last=1, bytes 0x10+i -> tx order 0x10,0x11,0x12,0x13,0x10…; no requester is served twice before the others.
- Packet lock: req 1 sends 0x01,0x02,0x03 (last on 0x03) while req 0 is valid with 0xFF -> rx sees 01,02,03 then FF; locked=1 until 0x03 is accepted. Repeat with LOCK_EN=0 -> interleaved 01,FF,02,…
- Back-pressure: hold tx_ready=0 externally for 50 cycles with req 0 valid -> req_ready stays 0, no tx_start; release -> transfer within 1 cycle.
- Reset mid-frame: assert rst 100 cycles into a 0x55 frame -> outputs take reset values immediately. After release, req 3 byte 0xC3 is held until uart_tx ready, then sent and received intact.
- Locked stall: req 2 sends 0x20 (last=0) then drops valid, while req 0 is valid -> no further tx_start for 1000 cycles; req 2 sends 0x21 with last=1 -> then req 0 is served.
